// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and command word layout
//
// Holds the default command width, the baud divider for a 50 MHz clock
// at 115200 baud, and the opcode/address/data split of the 16-bit
// command word used by the UART command path.

package uart_pkg;

  localparam int CMD_WIDTH_DEF = 16;
  localparam int CLK_HZ        = 50_000_000;
  localparam int BAUD_RATE     = 115_200;
  localparam int BAUD_DIV      = CLK_HZ / BAUD_RATE;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] addr;
    logic [7:0] data;
  } uart_cmd_t;

  function automatic uart_cmd_t make_cmd(input logic [3:0] opcode,
                                         input logic [3:0] addr,
                                         input logic [7:0] data);
    uart_cmd_t c;
    c.opcode = opcode;
    c.addr   = addr;
    c.data   = data;
    return c;
  endfunction

endpackage

// File: rtl/uart_cmdq_ram.sv
// rtl/uart_cmdq_ram.sv - command queue storage, sync write / async read
//
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr
// Contents are deliberately not reset.

module uart_cmdq_ram #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_queue.sv
// rtl/uart_cmd_queue.sv - first-word fall-through command queue feeding the UART
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   wr_cmd/wr_vld/wr_rdy - host-side push handshake
//   cmd_out/cmd_vld/cmd_rdy - UART-side pop handshake (head entry shown)
//   flush             - synchronous clear, overrides push and pop
//   level             - current occupancy, 0..DEPTH
//   ovf               - sticky refused-push flag, present only when
//                       UART_CMDQ_OVF_FLAG_EN is defined

module uart_cmd_queue
  import uart_pkg::*;
#(
  parameter int CMD_WIDTH = CMD_WIDTH_DEF,
  parameter int DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CMD_WIDTH-1:0]   wr_cmd,
  input  logic                   wr_vld,
  output logic                   wr_rdy,
  output logic [CMD_WIDTH-1:0]   cmd_out,
  output logic                   cmd_vld,
  input  logic                   cmd_rdy,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] level
`ifdef UART_CMDQ_OVF_FLAG_EN
  ,
  output logic                   ovf
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic          push;
  logic          pop;

  // Both handshake flags come from the registered level only, so a pop in
  // a full cycle cannot raise wr_rdy until after that edge.
  assign wr_rdy  = (level_q != FULL_LEVEL);
  assign cmd_vld = (level_q != '0);
  assign level   = level_q;

  assign push = wr_vld && wr_rdy && !flush;
  assign pop  = cmd_vld && cmd_rdy && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      level_q <= level_q + LVL_ONE;
      else if (pop && !push) level_q <= level_q - LVL_ONE;
    end
  end

`ifdef UART_CMDQ_OVF_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ovf <= 1'b0;
    else if (flush)             ovf <= 1'b0;
    else if (wr_vld && !wr_rdy) ovf <= 1'b1;
  end
`endif

  uart_cmdq_ram #(
    .W     (CMD_WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_cmd),
    .raddr (rd_ptr),
    .rdata (cmd_out)
  );

endmodule

// File: doc/uart_cmd_queue.md
UART_CMD_QUEUE -- requirements
Module: uart_cmd_queue

Interface
REQ-001 The block SHALL have parameter CMD_WIDTH, default 16: command word width, matching the UART command input.
REQ-002 The block SHALL have parameter DEPTH, default 8: queue entries, a power of two, 2..256.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port wr_cmd, input, CMD_WIDTH bits: command from the host side.
REQ-006 The block SHALL have port wr_vld, input, 1 bit: wr_cmd is valid.
REQ-007 The block SHALL have port wr_rdy, output, 1 bit: the queue can accept a command.
REQ-008 The block SHALL have port cmd_out, output, CMD_WIDTH bits: head command, wired to the UART cmd_in.
REQ-009 The block SHALL have port cmd_vld, output, 1 bit: cmd_out is valid.
REQ-010 The block SHALL have port cmd_rdy, input, 1 bit: the UART accepts cmd_out.
REQ-011 The block SHALL have port flush, input, 1 bit: synchronous queue clear.
REQ-012 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-013 A push SHALL occur on a rising clk edge where wr_vld && wr_rdy; a pop SHALL occur where cmd_vld && cmd_rdy.
REQ-014 wr_rdy SHALL equal (level != DEPTH) and SHALL be registered or derived from registered state only, with no combinational path from cmd_rdy.
REQ-015 cmd_vld SHALL equal (level != 0); cmd_out SHALL present the oldest entry (first-word fall-through).
REQ-016 Latency: a push at edge N SHALL make cmd_vld high after edge N when the queue was empty; there SHALL be no same-cycle bypass.
REQ-017 Push and pop at the same edge SHALL leave level unchanged and advance both pointers.
REQ-018 Full: wr_rdy SHALL stay low for the whole cycle even if a pop occurs in that cycle; it SHALL rise after the pop edge.
REQ-019 Empty: cmd_out SHALL be don't-care, and the bench SHALL check it only while cmd_vld is high.
REQ-020 Pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-021 At an edge where flush is high, pointers and level SHALL clear, any push or pop in that cycle SHALL be discarded, and flush SHALL have priority over both.
REQ-022 Once pushed, cmd_out SHALL hold stable while cmd_vld is high and cmd_rdy is low.

Reset
REQ-023 While rst_n is low, level, read pointer and write pointer SHALL be 0, cmd_vld SHALL be 0, and wr_rdy SHALL be 1 from the first edge after release.
REQ-024 Storage contents SHALL NOT be reset, and cmd_out SHALL be X-tolerant while cmd_vld is 0.
REQ-025 Reset asserted mid-operation SHALL drop all queued commands immediately (asynchronously), and no partial pop SHALL reach the UART.

Configuration
REQ-026 With macro UART_CMDQ_OVF_FLAG_EN defined, the block SHALL add output ovf (1 bit, reset 0), which SHALL be sticky-set on any edge where wr_vld is high and wr_rdy is low and SHALL be cleared only by flush or reset.
REQ-027 Without UART_CMDQ_OVF_FLAG_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Shared package uart_pkg SHALL hold the CMD_WIDTH default constant, the baud-divider constant (50 MHz / 115200), and the command field typedef (opcode/address/data split of the 16-bit word).
REQ-029 Storage SHALL be a single sub-module uart_cmdq_ram: DEPTH x CMD_WIDTH, one synchronous write port and one asynchronous read port, with no reset.
REQ-030 Pointer, level and flush control SHALL reside in uart_cmd_queue.

Verification
REQ-031 The bench SHALL cover: reset release, then push 0xA55A with cmd_rdy=0 -> cmd_vld=1 and cmd_out=0xA55A one edge later, level=1.
REQ-032 The bench SHALL cover: push 8 words 0x0001..0x0008 with cmd_rdy=0 -> level=8, wr_rdy=0; a 9th push is refused and ovf=1 when the macro is defined.
REQ-033 The bench SHALL cover: full queue, cmd_rdy=1 with wr_vld=1 in the same cycle -> pop of 0x0001, no push, level=7, then wr_rdy=1.
REQ-034 The bench SHALL cover: continuous push and pop of 20 words with both handshakes high -> level constant, output order 0x0001..0x0014, pointer wrap exercised.
REQ-035 The bench SHALL cover: level=5, flush=1 together with wr_vld=1 and cmd_rdy=1 -> level=0, cmd_vld=0, ovf=0, and neither transfer counted.
REQ-036 The bench SHALL cover: level=3, rst_n pulsed low between edges -> cmd_vld=0 and level=0 immediately, and wr_rdy=1 after release.
